// File: rtl/starflux_pkg.sv
// starflux_pkg: game-state encodings, grid index helper and column-width macro
// shared by the multi-enemy game logic core and its enemy units.
`ifndef STARFLUX_XW
`define STARFLUX_XW(w) ($clog2(w))
`endif

package starflux_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PLAY      = 2'd1,
        ST_INVULN    = 2'd2,
        ST_GAME_OVER = 2'd3
    } game_state_e;

    function automatic int idx(input int x, input int y, input int grid_w);
        return y * grid_w + x;
    endfunction

endpackage

// File: rtl/enemy_unit.sv
// enemy_unit: one enemy's bouncing column, direction and fire cooldown;
// fire_o pulses combinationally on the grid tick where this enemy shoots.
module enemy_unit #(
    parameter int             GRID_W       = 160,
    parameter int             COOLDOWN_MAX = 15,
    parameter int             XW           = 8,
    parameter int             CW           = 4,
    parameter logic [XW-1:0]  INIT_X       = '0,
    parameter logic [CW-1:0]  INIT_CD      = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          restart_i,
    input  logic          active_i,
    input  logic          move_tick_i,
    input  logic          grid_tick_i,
    input  logic          fire_en_i,
    output logic [XW-1:0] x_o,
    output logic          fire_o
);

    logic [XW-1:0] x_q, x_d;
    logic          dir_q, dir_d;
    logic [CW-1:0] cd_q, cd_d;

    assign x_o    = x_q;
    assign fire_o = active_i & grid_tick_i & fire_en_i & (cd_q == '0);

    // dir_q=1 means moving right; edges reflect with a step away from the wall
    always_comb begin
        x_d   = x_q;
        dir_d = dir_q;
        cd_d  = cd_q;
        if (restart_i) begin
            x_d   = INIT_X;
            dir_d = 1'b1;
            cd_d  = INIT_CD;
        end else if (active_i) begin
            if (move_tick_i) begin
                if (dir_q && x_q == XW'(GRID_W - 1)) begin
                    dir_d = 1'b0;
                    x_d   = x_q - XW'(1);
                end else if (!dir_q && x_q == '0) begin
                    dir_d = 1'b1;
                    x_d   = x_q + XW'(1);
                end else begin
                    x_d = dir_q ? x_q + XW'(1) : x_q - XW'(1);
                end
            end
            if (grid_tick_i)
                cd_d = fire_o ? CW'(COOLDOWN_MAX) : (cd_q != '0 ? cd_q - CW'(1) : cd_q);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_q   <= INIT_X;
            dir_q <= 1'b1;
            cd_q  <= INIT_CD;
        end else begin
            x_q   <= x_d;
            dir_q <= dir_d;
            cd_q  <= cd_d;
        end
    end

endmodule

// File: rtl/multi_enemy_logic_handler.sv
// multi_enemy_logic_handler: play-state machine, player, NUM_ENEMIES shooters,
// scrolling bullet grid, collision/invulnerability and score tracking.
module multi_enemy_logic_handler
    import starflux_pkg::*;
#(
    parameter int  GRID_W       = 160,
    parameter int  GRID_H       = 120,
    parameter int  NUM_ENEMIES  = 4,
    parameter int  HEALTH_MAX   = 4,
    parameter int  COOLDOWN_MAX = 15,
    parameter int  INVULN_TICKS = 8,
    parameter int  SCORE_W      = 8,
    localparam int XW           = `STARFLUX_XW(GRID_W),
    localparam int HW           = $clog2(HEALTH_MAX + 1),
    localparam int GN           = GRID_W * GRID_H
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      move_left,
    input  logic                      move_right,
    input  logic                      fire_en,
    input  logic                      grid_tick,
    input  logic                      move_tick,
    input  logic                      score_tick,
    output logic [XW-1:0]             user_x,
    output logic [NUM_ENEMIES*XW-1:0] enemy_x,
    output logic [GN-1:0]             enem_grid,
    output logic [HW-1:0]             ship_health,
    output logic [SCORE_W-1:0]        current_score,
    output logic [SCORE_W-1:0]        best_score,
    output logic [1:0]                game_state,
    output logic                      hit
);

    localparam int CMAX = (COOLDOWN_MAX > NUM_ENEMIES) ? COOLDOWN_MAX : NUM_ENEMIES;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int IW   = $clog2(INVULN_TICKS + 2);
    localparam int GIW  = $clog2(GN);

    game_state_e          state_q, state_d;
    logic [XW-1:0]        ux_q, ux_d;
    logic [GN-1:0]        grid_q, grid_d, shifted;
    logic [HW-1:0]        health_q, health_d;
    logic [SCORE_W-1:0]   score_q, score_d, best_q, best_d;
    logic [IW-1:0]        inv_q, inv_d;
    logic                 hit_q, hit_d;
    logic                 active, restart, collide;
    logic [NUM_ENEMIES-1:0] fire;
    logic [GRID_W-1:0]    row0;
    logic [GIW-1:0]       hit_idx;

    assign active  = (state_q == ST_PLAY) || (state_q == ST_INVULN);
    assign restart = start && (state_q == ST_IDLE || state_q == ST_GAME_OVER);

    for (genvar i = 0; i < NUM_ENEMIES; i++) begin : g_enemy
        enemy_unit #(
            .GRID_W      (GRID_W),
            .COOLDOWN_MAX(COOLDOWN_MAX),
            .XW          (XW),
            .CW          (CW),
            .INIT_X      (XW'(i * (GRID_W / NUM_ENEMIES))),
            .INIT_CD     (CW'(i))
        ) u_enemy (
            .clk        (clk),
            .reset      (reset),
            .restart_i  (restart),
            .active_i   (active),
            .move_tick_i(move_tick),
            .grid_tick_i(grid_tick),
            .fire_en_i  (fire_en),
            .x_o        (enemy_x[i*XW +: XW]),
            .fire_o     (fire[i])
        );
    end

    // enemy_x here is still the pre-move position, so shots leave from where the enemy was
    always_comb begin
        row0 = '0;
        for (int i = 0; i < NUM_ENEMIES; i++)
            if (fire[i]) row0[enemy_x[i*XW +: XW]] = 1'b1;
    end

    assign shifted = {grid_q[GN-GRID_W-1:0], row0};
    assign hit_idx = GIW'(idx(int'(ux_q), GRID_H - 1, GRID_W));
    assign collide = shifted[hit_idx];

    always_comb begin
        state_d  = state_q;
        ux_d     = ux_q;
        grid_d   = grid_q;
        health_d = health_q;
        score_d  = score_q;
        inv_d    = inv_q;
        hit_d    = 1'b0;
        best_d   = (score_q > best_q) ? score_q : best_q;
        if (restart) begin
            state_d  = ST_PLAY;
            ux_d     = XW'(GRID_W / 2);
            grid_d   = '0;
            health_d = HW'(HEALTH_MAX);
            score_d  = '0;
            inv_d    = '0;
        end else if (active) begin
            if (move_right && !move_left && ux_q != XW'(GRID_W - 1))
                ux_d = ux_q + XW'(1);
            else if (move_left && !move_right && ux_q != '0)
                ux_d = ux_q - XW'(1);
            if (score_tick && score_q != '1)
                score_d = score_q + SCORE_W'(1);
            if (grid_tick) begin
                grid_d          = shifted;
                grid_d[hit_idx] = 1'b0;
                if (collide && state_q == ST_PLAY) begin
                    hit_d    = 1'b1;
                    health_d = health_q - HW'(1);
                    state_d  = (health_q == HW'(1)) ? ST_GAME_OVER : ST_INVULN;
                    inv_d    = IW'(INVULN_TICKS);
                end else if (state_q == ST_INVULN) begin
                    inv_d = (inv_q != '0) ? inv_q - IW'(1) : inv_q;
                    if (inv_q <= IW'(1)) state_d = ST_PLAY;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            ux_q     <= XW'(GRID_W / 2);
            grid_q   <= '0;
            health_q <= HW'(HEALTH_MAX);
            score_q  <= '0;
            best_q   <= '0;
            inv_q    <= '0;
            hit_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ux_q     <= ux_d;
            grid_q   <= grid_d;
            health_q <= health_d;
            score_q  <= score_d;
            best_q   <= best_d;
            inv_q    <= inv_d;
            hit_q    <= hit_d;
        end
    end

    assign user_x        = ux_q;
    assign enem_grid     = grid_q;
    assign ship_health   = health_q;
    assign current_score = score_q;
    assign best_score    = best_q;
    assign game_state    = state_q;
    assign hit           = hit_q;

endmodule
